// File: rtl/soft_rst_pkg.sv
// Shared types and helpers for the soft-reset sequencer.
//   state_t   : sequencer state encoding (IDLE/HALT/RST/DONE)
//   cnt_width : bit width for a saturating counter that must hold 0..max_val
package soft_rst_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'h0,
        HALT = 2'h1,
        RST  = 2'h2,
        DONE = 2'h3
    } state_t;

    // Width needed to represent max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        if (w == 0) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/soft_rst_quiet_qual.sv
// Quiet qualification for the soft-reset sequencer.
// Tracks how many consecutive cycles every unmasked channel has been quiet.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ch_quiet   : per-channel dormant flags
//   ch_mask    : 1 = ignore that channel's quiet flag
//   clr        : hold the run counter at zero (sequencer not halting)
//   qualified  : combinational; 1 when the coming edge completes the window
module soft_rst_quiet_qual
    import soft_rst_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned QUIET_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_quiet,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              clr,
    output logic              qualified
);

    localparam int unsigned QW    = cnt_width(QUIET_CYCLES);
    localparam int unsigned QLAST = QUIET_CYCLES - 1;

    logic          all_quiet;
    logic [QW-1:0] qcnt;
    logic [QW-1:0] qcnt_d;

    // Masked channels count as quiet; the run restarts on any noisy cycle.
    always_comb begin
        all_quiet = &(ch_quiet | ch_mask);
        qcnt_d    = '0;
        qualified = 1'b0;
        if (!clr && all_quiet) begin
            qcnt_d    = (qcnt == QW'(QUIET_CYCLES)) ? qcnt : qcnt + QW'(1);
            qualified = (qcnt == QW'(QLAST));
        end
    end

    // Run-length register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qcnt <= '0;
        end else begin
            qcnt <= qcnt_d;
        end
    end

endmodule

// File: rtl/soft_rst_seq.sv
// Soft-reset sequencer between the register block and the channel engines.
// A request halts DMA, waits for all unmasked channels to be quiet for
// QUIET_CYCLES (or for TIMEOUT_CYCLES in HALT), holds the core soft reset and
// the host-side async reset for HOLD_CYCLES, then completes a four-phase
// done handshake.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   req_soft_rst   : level request (four-phase)
//   soft_rst_dne   : done, held until the request drops
//   ch_quiet       : per-channel dormant flags
//   ch_mask        : 1 = ignore that channel
//   dma_halt       : reset pending, halt activity
//   soft_rst       : synchronous soft reset to the core side
//   hs_async_rst_n : host-side reset, active-low
//   timeout_err    : sticky, last sequence left HALT by timeout
//   busy           : sequencer not idle
module soft_rst_seq
    import soft_rst_pkg::*;
#(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned HOLD_CYCLES    = 8,
    parameter int unsigned QUIET_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_soft_rst,
    output logic              soft_rst_dne,
    input  logic [NUM_CH-1:0] ch_quiet,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              dma_halt,
    output logic              soft_rst,
    output logic              hs_async_rst_n,
    output logic              timeout_err,
    output logic              busy
);

    // A disabled timeout still gets a one-bit counter so widths stay legal.
    localparam int unsigned TMAX  = (TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES;
    localparam int unsigned TLAST = TMAX - 1;
    localparam int unsigned TW    = cnt_width(TMAX);
    localparam int unsigned HLAST = HOLD_CYCLES - 1;
    localparam int unsigned HW    = cnt_width(HOLD_CYCLES);
    localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);

    state_t        state;
    state_t        state_d;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_d;
    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_d;
    logic          timeout_err_d;
    logic          timeout_hit;
    logic          qualified;
    logic          qual_clr;

    // Quiet run counter only runs while halting.
    assign qual_clr = (state != HALT);

    soft_rst_quiet_qual #(
        .NUM_CH       (NUM_CH),
        .QUIET_CYCLES (QUIET_CYCLES)
    ) u_quiet_qual (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_quiet  (ch_quiet),
        .ch_mask   (ch_mask),
        .clr       (qual_clr),
        .qualified (qualified)
    );

    // Next-state, counters and sticky error.
    always_comb begin
        state_d       = state;
        tcnt_d        = '0;
        hcnt_d        = '0;
        timeout_err_d = timeout_err;
        timeout_hit   = TO_EN && (tcnt == TW'(TLAST));
        case (state)
            IDLE: begin
                if (req_soft_rst) begin
                    state_d       = HALT;
                    timeout_err_d = 1'b0;
                end
            end
            HALT: begin
                tcnt_d = (tcnt == TW'(TMAX)) ? tcnt : tcnt + TW'(1);
                // Qualification takes priority over a coincident timeout.
                if (qualified) begin
                    state_d = RST;
                end else if (timeout_hit) begin
                    state_d       = RST;
                    timeout_err_d = 1'b1;
                end
            end
            RST: begin
                hcnt_d = (hcnt == HW'(HOLD_CYCLES)) ? hcnt : hcnt + HW'(1);
                if (hcnt == HW'(HLAST)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!req_soft_rst) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            tcnt           <= '0;
            hcnt           <= '0;
            timeout_err    <= 1'b0;
            dma_halt       <= 1'b0;
            soft_rst       <= 1'b0;
            hs_async_rst_n <= 1'b0;
            soft_rst_dne   <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_d;
            tcnt           <= tcnt_d;
            hcnt           <= hcnt_d;
            timeout_err    <= timeout_err_d;
            dma_halt       <= (state_d == HALT) || (state_d == RST);
            soft_rst       <= (state_d == RST);
            hs_async_rst_n <= (state_d != RST);
            soft_rst_dne   <= (state_d == DONE);
            busy           <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_soft_rst_seq.sv
// Scoreboard bench for soft_rst_seq: one instance with default parameters and
// one with the timeout disabled. Each cycle the stimulus advances a
// behavioural model and queues the expected outputs; a monitor compares.
module tb_soft_rst_seq;

    localparam int HOLD  = 8;
    localparam int QUIET = 2;
    localparam int TO    = 64;

    typedef struct {
        int phase;   // 0 idle, 1 halting, 2 holding reset, 3 done
        int run;     // consecutive quiet cycles seen while halting
        int age;     // cycles spent halting
        int hold;    // reset-hold cycles still to go
        bit terr;
    } mst_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_soft_rst = 1'b0;
    logic [3:0] ch_quiet = 4'hF;
    logic [3:0] ch_mask = 4'h0;
    logic       soft_rst_dne, dma_halt, soft_rst, hs_async_rst_n, timeout_err, busy;

    logic       nt_req = 1'b0;
    logic [3:0] nt_quiet = 4'hF;
    logic [3:0] nt_mask = 4'h0;
    logic       nt_dne, nt_halt, nt_srst, nt_hs_n, nt_terr, nt_busy;

    // Values applied at the next negedge.
    logic       nx_rst_n = 1'b0;
    logic       nx_req = 1'b0;
    logic [3:0] nx_quiet = 4'hF;
    logic [3:0] nx_mask = 4'h0;
    logic       nx_nt_req = 1'b0;
    logic [3:0] nx_nt_quiet = 4'hF;

    mst_t       ms0;
    mst_t       ms1;
    logic [5:0] exp0_q[$];
    logic [5:0] exp1_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         tid = 0;

    always #5 clk = ~clk;

    soft_rst_seq dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_soft_rst   (req_soft_rst),
        .soft_rst_dne   (soft_rst_dne),
        .ch_quiet       (ch_quiet),
        .ch_mask        (ch_mask),
        .dma_halt       (dma_halt),
        .soft_rst       (soft_rst),
        .hs_async_rst_n (hs_async_rst_n),
        .timeout_err    (timeout_err),
        .busy           (busy)
    );

    soft_rst_seq #(.TIMEOUT_CYCLES(0)) dut_nt (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_soft_rst   (nt_req),
        .soft_rst_dne   (nt_dne),
        .ch_quiet       (nt_quiet),
        .ch_mask        (nt_mask),
        .dma_halt       (nt_halt),
        .soft_rst       (nt_srst),
        .hs_async_rst_n (nt_hs_n),
        .timeout_err    (nt_terr),
        .busy           (nt_busy)
    );

    // Reference behaviour for one clock edge.
    function automatic mst_t mstep(mst_t s, bit rn, bit rq, logic [3:0] q,
                                   logic [3:0] m, int to);
        mst_t n;
        bit   aq;
        n  = s;
        aq = &(q | m);
        if (!rn) begin
            n.phase = 0; n.run = 0; n.age = 0; n.hold = 0; n.terr = 1'b0;
            return n;
        end
        case (s.phase)
            0: if (rq) begin
                n.phase = 1; n.run = 0; n.age = 0; n.terr = 1'b0;
            end
            1: begin
                n.run = aq ? s.run + 1 : 0;
                n.age = s.age + 1;
                if (n.run >= QUIET) begin
                    n.phase = 2; n.hold = HOLD;
                end else if (to != 0 && n.age >= to) begin
                    n.phase = 2; n.hold = HOLD; n.terr = 1'b1;
                end
            end
            2: begin
                n.hold = s.hold - 1;
                if (n.hold == 0) n.phase = 3;
            end
            default: if (!rq) n.phase = 0;
        endcase
        return n;
    endfunction

    // Expected {dma_halt, soft_rst, hs_async_rst_n, timeout_err, busy, soft_rst_dne}.
    function automatic logic [5:0] mout(mst_t s, bit rn);
        if (!rn) return 6'b000000;
        return {(s.phase == 1 || s.phase == 2), (s.phase == 2), (s.phase != 2),
                s.terr, (s.phase != 0), (s.phase == 3)};
    endfunction

    task automatic tick();
        @(negedge clk);
        rst_n        = nx_rst_n;
        req_soft_rst = nx_req;
        ch_quiet     = nx_quiet;
        ch_mask      = nx_mask;
        nt_req       = nx_nt_req;
        nt_quiet     = nx_nt_quiet;
        ms0 = mstep(ms0, nx_rst_n, nx_req, nx_quiet, nx_mask, TO);
        ms1 = mstep(ms1, nx_rst_n, nx_nt_req, nx_nt_quiet, 4'h0, 0);
        exp0_q.push_back(mout(ms0, nx_rst_n));
        exp1_q.push_back(mout(ms1, nx_rst_n));
    endtask

    // Keep current inputs until done, then drop the request and return to idle.
    task automatic finish_seq();
        for (int i = 0; i < 300 && ms0.phase != 3; i++) tick();
        nx_req = 1'b0;
        for (int i = 0; i < 5 && ms0.phase != 0; i++) tick();
        tick();
    endtask

    // Monitor: compare after every rising edge.
    initial begin
        logic [5:0] e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp0_q.size() > 0) begin
                e = exp0_q.pop_front();
                checks++;
                if ({dma_halt, soft_rst, hs_async_rst_n, timeout_err, busy, soft_rst_dne} !== e) begin
                    errors++;
                    $display("FAIL main test=%0d cyc=%0d got=%b exp=%b (halt,srst,hs_n,terr,busy,dne)",
                             tid, cyc, {dma_halt, soft_rst, hs_async_rst_n, timeout_err, busy,
                             soft_rst_dne}, e);
                end
            end
            if (exp1_q.size() > 0) begin
                e = exp1_q.pop_front();
                checks++;
                if ({nt_halt, nt_srst, nt_hs_n, nt_terr, nt_busy, nt_dne} !== e) begin
                    errors++;
                    $display("FAIL no_timeout test=%0d cyc=%0d got=%b exp=%b (halt,srst,hs_n,terr,busy,dne)",
                             tid, cyc, {nt_halt, nt_srst, nt_hs_n, nt_terr, nt_busy, nt_dne}, e);
                end
            end
        end
    end

    initial begin
        ms0 = '{0, 0, 0, 0, 1'b0};
        ms1 = '{0, 0, 0, 0, 1'b0};

        // Power-up: reset held, outputs all low; release.
        tid = 1;
        nx_quiet = 4'hF;
        repeat (5) tick();
        nx_rst_n = 1'b1;
        repeat (3) tick();

        // Nominal sequence.
        tid = 2;
        nx_req = 1'b1;
        repeat (14) tick();
        nx_req = 1'b0;
        repeat (3) tick();

        // Glitchy quiet during HALT.
        tid = 3;
        nx_req = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            nx_quiet = (i % 2 == 0) ? 4'hF : 4'hE;
            tick();
        end
        nx_quiet = 4'hF;
        finish_seq();

        // Mask hides a noisy channel, then timeout without mask, then clear.
        tid = 4;
        nx_quiet = 4'h7; nx_mask = 4'h8; nx_req = 1'b1;
        finish_seq();
        nx_mask = 4'h0; nx_req = 1'b1;
        finish_seq();
        nx_quiet = 4'hF; nx_req = 1'b1;
        finish_seq();

        // Qualification completes on the last timeout cycle.
        tid = 5;
        nx_quiet = 4'h0; nx_req = 1'b1;
        tick();
        repeat (62) tick();
        nx_quiet = 4'hF;
        finish_seq();

        // Timeout disabled: stays halted indefinitely.
        tid = 6;
        nx_nt_quiet = 4'h0; nx_nt_req = 1'b1;
        repeat (1000) tick();
        nx_nt_quiet = 4'hF;
        for (int i = 0; i < 40 && ms1.phase != 3; i++) tick();
        nx_nt_req = 1'b0;
        repeat (3) tick();

        // Reset pulsed during the fourth RST cycle.
        tid = 7;
        nx_quiet = 4'hF; nx_req = 1'b1;
        for (int i = 0; i < 20 && ms0.phase != 2; i++) tick();
        repeat (3) tick();
        nx_rst_n = 1'b0;
        tick();
        #1;
        checks++;
        if ({dma_halt, soft_rst, hs_async_rst_n, soft_rst_dne, busy} !== 5'b00000) begin
            errors++;
            $display("FAIL async_reset got=%b exp=00000 (halt,srst,hs_n,dne,busy)",
                     {dma_halt, soft_rst, hs_async_rst_n, soft_rst_dne, busy});
        end
        nx_req = 1'b0;
        repeat (2) tick();
        nx_rst_n = 1'b1;
        repeat (3) tick();

        // Request dropped during HALT still completes; DONE lasts one cycle.
        tid = 8;
        nx_req = 1'b1;
        tick();
        nx_req = 1'b0;
        repeat (14) tick();

        // Randomised sequences.
        tid = 9;
        for (int s = 0; s < 25; s++) begin
            nx_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            nx_req  = 1'b1;
            for (int c = 0; c < 200; c++) begin
                nx_quiet = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                if (ms0.phase == 1 || ms0.phase == 2) begin
                    if ($urandom_range(0, 7) == 0) nx_req = ~nx_req;
                end else if (ms0.phase == 3) begin
                    if ($urandom_range(0, 2) == 0) nx_req = 1'b0;
                end else if (c > 0) begin
                    break;
                end
                tick();
            end
            nx_req = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end

        repeat (3) tick();
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/soft_rst_seq.md
Name: soft_rst_seq

Overview:
Parametrised soft-reset sequencer for a multi-channel datapath.
- On a software request it halts DMA and waits until every enabled channel has been quiet for a qualification window, with a bounded timeout.
- It then asserts the synchronous soft reset and the asynchronous host-side reset for a programmable hold time, and completes a four-phase done handshake.
- It sits between the register block (software land) and the per-channel TX/RX engines.

Parameters:
- NUM_CH, 4, number of channels whose quiet status gates the reset.
- HOLD_CYCLES, 8, cycles soft_rst stays asserted (>=1).
- QUIET_CYCLES, 2, consecutive all-quiet cycles required before reset (>=1).
- TIMEOUT_CYCLES, 64, maximum cycles spent in HALT; 0 disables the timeout.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req_soft_rst  input  1  soft reset request, level, four-phase.
- soft_rst_dne  output  1  done; high until req_soft_rst drops.
- ch_quiet  input  NUM_CH  per-channel dormant flags, synchronous to clk.
- ch_mask  input  NUM_CH  1 = ignore that channel's quiet flag.
- dma_halt  output  1  reset pending; halt activity.
- soft_rst  output  1  synchronous soft reset to core side.
- hs_async_rst_n  output  1  async reset to host side, active-low.
- timeout_err  output  1  sticky: last sequence left HALT by timeout.
- busy  output  1  state != IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, dma_halt=0, soft_rst=0, soft_rst_dne=0, timeout_err=0, busy=0, hs_async_rst_n=0. hs_async_rst_n goes to 1 on the first clk edge after rst_n deasserts.
- Output registering: all outputs are registered and decoded from next-state. An output belonging to a state is valid in the same cycle the state register holds that state.
- State encoding: IDLE=2'h0, HALT=2'h1, RST=2'h2, DONE=2'h3.
- Definitions:
  - all_quiet = &(ch_quiet | ch_mask).
  - qcnt = consecutive all-quiet counter.
  - tcnt = HALT dwell counter.
  - hcnt = hold counter.
  - Counters use $clog2(max+1) bits and saturate; they never wrap.
- IDLE:
  - On req_soft_rst=1: go to HALT; clear qcnt and tcnt; clear timeout_err.
  - Otherwise stay in IDLE.
- HALT:
  - Outputs: dma_halt=1, busy=1.
  - qcnt increments while all_quiet=1 and clears to 0 on any cycle with all_quiet=0.
  - tcnt increments every cycle.
  - Exit on qualification: if all_quiet=1 and qcnt==QUIET_CYCLES-1, go to RST. HALT then lasts exactly QUIET_CYCLES cycles when channels are already quiet.
  - Exit on timeout: if TIMEOUT_CYCLES!=0 and tcnt==TIMEOUT_CYCLES-1 without qualification, go to RST and set timeout_err.
  - Simultaneous qualification and timeout on the same cycle: qualification wins; timeout_err stays 0.
  - Mask or quiet changes take effect in the cycle they are sampled.
  - ch_mask all ones: all_quiet is permanently 1.
- RST:
  - Outputs: dma_halt=1, soft_rst=1, hs_async_rst_n=0, busy=1.
  - hcnt counts from 0; on hcnt==HOLD_CYCLES-1 go to DONE. RST lasts exactly HOLD_CYCLES cycles.
- DONE:
  - Outputs: soft_rst_dne=1, busy=1; dma_halt=0, soft_rst=0, hs_async_rst_n=1.
  - Stay while req_soft_rst=1; go to IDLE on req_soft_rst=0.
- Request deassertion: req_soft_rst falling in HALT or RST is ignored; the sequence always completes.
- Re-request: req held or re-raised in the cycle DONE->IDLE occurs is not accepted until seen high in IDLE. Minimum one IDLE cycle between sequences.
- timeout_err is sticky until the next request is accepted in IDLE.
- rst_n asserted mid-sequence: immediate return to IDLE with reset values; no done pulse is generated.

Decomposition:
- Package soft_rst_pkg: state_t enum (2-bit, the encodings above), IDLE/HALT/RST/DONE constants, and a clog2-based counter-width function.
- Sub-module soft_rst_quiet_qual (NUM_CH, QUIET_CYCLES):
  - Inputs: ch_quiet, ch_mask, clr.
  - Logic: mask-OR-AND reduction plus qcnt.
  - Output: qualified, 1 when the next edge completes the window.
- The top level holds the FSM, tcnt, hcnt and output registers.

Test Plan:
- Power-up: rst_n low 5 cycles, ch_quiet=4'hF -> all outputs 0, including hs_async_rst_n. hs_async_rst_n=1 one edge after release, state IDLE.
- Nominal, defaults, ch_quiet=4'hF, ch_mask=0, req raised at edge 0:
  - dma_halt=1 for cycles 1-10.
  - soft_rst=1 and hs_async_rst_n=0 for cycles 3-10.
  - soft_rst_dne=1 from cycle 11 until 1 cycle after req drops; timeout_err=0.
- Glitchy quiet: ch_quiet toggles 4'hF/4'hE alternately for 10 HALT cycles, then 4'hF -> RST entered exactly 2 cycles after steady 4'hF.
- Mask: ch_quiet=4'h7, ch_mask=4'h8 -> qualifies normally; same with ch_mask=0 -> HALT lasts 64 cycles, then RST with timeout_err=1. The next req clears timeout_err.
- Simultaneous events: all-quiet window completes exactly at tcnt=63 -> RST, timeout_err=0. TIMEOUT_CYCLES=0 with ch_quiet=0 -> stays in HALT indefinitely (check 1000 cycles).
- Disturbances:
  - rst_n pulsed low during RST cycle 4 -> soft_rst=0 and dma_halt=0 immediately, hs_async_rst_n=0, no soft_rst_dne.
  - req dropped during HALT -> sequence still completes; DONE lasts 1 cycle.
